// File: rtl/motion_mask.sv
`default_nettype none
// ============================================================================
//  Module   : motion_mask
//  Purpose  : Background subtraction. Pops one background and one current
//             pixel together, thresholds |cur - bg| into an 8'hFF/8'h00 mask
//             pixel, tracks frame position and pulses frame_done at frame end.
//  Option   : `define MOTION_MASK_COUNT_EN adds the per-frame motion_count.
//  Revision : 1.0 - initial release
// ============================================================================
module motion_mask #(
    parameter int         WIDTH     = 720,
    parameter int         HEIGHT    = 540,
    parameter logic [7:0] THRESHOLD = 8'd50
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       bg_rd_en,
    input  logic       bg_empty,
    input  logic [7:0] bg_dout,
    output logic       cur_rd_en,
    input  logic       cur_empty,
    input  logic [7:0] cur_dout,
    output logic       mask_wr_en,
    input  logic       mask_full,
    output logic [7:0] mask_din,
    output logic       frame_done
`ifdef MOTION_MASK_COUNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] motion_count
`endif
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int PIX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [PIX_W-1:0] c_pix_last = PIX_W'(TOTAL - 1);

    typedef enum logic [0:0] {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_diff_q;
    logic [PIX_W-1:0] r_pix_cnt;
    logic             r_frame_done;

    logic             w_pop;
    logic             w_write;
    logic             w_motion;
    logic             w_last;
    logic signed [8:0] w_diff;
    logic [8:0]       w_diff_neg;
    logic [7:0]       w_mag;

    // Nine-bit signed difference cannot overflow; its magnitude fits in 8 bits.
    assign w_diff     = $signed({1'b0, cur_dout}) - $signed({1'b0, bg_dout});
    assign w_diff_neg = 9'(-w_diff);
    assign w_mag      = w_diff[8] ? w_diff_neg[7:0] : w_diff[7:0];

    assign w_motion = (r_diff_q > THRESHOLD);
    assign w_last   = w_write && (r_pix_cnt == c_pix_last);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_READ: begin
                if (!bg_empty && !cur_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!mask_full) begin
                    w_write      = 1'b1;
                    w_state_next = S_READ;
                end
            end
            default: w_state_next = S_READ;
        endcase
    end

    assign bg_rd_en   = w_pop;
    assign cur_rd_en  = w_pop;
    assign mask_wr_en = w_write;
    assign mask_din   = (w_write && w_motion) ? 8'hFF : 8'h00;
    assign frame_done = r_frame_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_READ;
            r_diff_q     <= 8'd0;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_last;
            if (w_pop) begin
                r_diff_q <= w_mag;
            end
            if (w_write) begin
                r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
            end
        end
    end

`ifdef MOTION_MASK_COUNT_EN
    localparam int CNT_W = $clog2(TOTAL + 1);

    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_motion_count;

    // The last pixel's own motion bit is folded in on the publishing edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc          <= '0;
            r_motion_count <= '0;
        end else if (w_write) begin
            if (w_last) begin
                r_motion_count <= r_acc + CNT_W'(w_motion);
                r_acc          <= '0;
            end else begin
                r_acc <= r_acc + CNT_W'(w_motion);
            end
        end
    end

    assign motion_count = r_motion_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motion_mask.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motion_mask
//  Purpose  : Scoreboard bench for motion_mask with a 4x2 frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motion_mask;

    localparam int         W   = 4;
    localparam int         H   = 2;
    localparam int         NPX = W * H;
    localparam logic [7:0] THR = 8'd50;

    logic       clk;
    logic       reset_n;
    logic       bg_rd_en, cur_rd_en, mask_wr_en, frame_done;
    logic       bg_empty, cur_empty, mask_full;
    logic [7:0] bg_dout, cur_dout, mask_din;
`ifdef MOTION_MASK_COUNT_EN
    logic [$clog2(NPX+1)-1:0] motion_count;
`endif

    motion_mask #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(THR)) dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .bg_rd_en   (bg_rd_en),
        .bg_empty   (bg_empty),
        .bg_dout    (bg_dout),
        .cur_rd_en  (cur_rd_en),
        .cur_empty  (cur_empty),
        .cur_dout   (cur_dout),
        .mask_wr_en (mask_wr_en),
        .mask_full  (mask_full),
        .mask_din   (mask_din),
        .frame_done (frame_done)
`ifdef MOTION_MASK_COUNT_EN
        ,
        .motion_count (motion_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;
        bit         last;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_pix  = 0;
    int   m_acc  = 0;
    bit   fd_pending = 0;
    int   fd_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected mask comes from the caller's hand-computed value.
    task automatic push_exp(input logic [7:0] mask);
        exp_t e;
        e.mask = mask;
        e.last = (m_pix == NPX - 1);
        if (mask == 8'hFF) m_acc++;
        e.cnt  = m_acc;
        if (e.last) begin
            m_pix = 0;
            m_acc = 0;
        end else begin
            m_pix++;
        end
        q.push_back(e);
    endtask

    // Monitor: compare every DUT write against the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        bit   nxt;
        if (!reset_n) begin
            fd_pending = 0;
        end else begin
            nxt = 0;
            check("frame_done", int'(frame_done), int'(fd_pending));
`ifdef MOTION_MASK_COUNT_EN
            if (fd_pending) check("motion_count", int'(motion_count), fd_cnt);
`endif
            if (!mask_wr_en) begin
                check("mask_din_idle", int'(mask_din), 0);
            end else if (q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = q.pop_front();
                check("mask_din", int'(mask_din), int'(e.mask));
                nxt    = e.last;
                fd_cnt = e.cnt;
            end
            fd_pending = nxt;
        end
    end

    // Entered #1 after a rising edge with the DUT in S_READ.
    task automatic send_pixel(input logic [7:0] bg, input logic [7:0] cur,
                              input logic [7:0] exp_mask, input int full_cycles);
        push_exp(exp_mask);
        bg_dout   = bg;
        cur_dout  = cur;
        bg_empty  = 1'b0;
        cur_empty = 1'b0;
        mask_full = 1'b0;
        @(negedge clk);
        check("pop_pair", int'({bg_rd_en, cur_rd_en}), 3);
        @(posedge clk); #1;
        if (full_cycles > 0) begin
            mask_full = 1'b1;
            for (int i = 0; i < full_cycles; i++) begin
                @(negedge clk);
                check("stall_quiet", int'({bg_rd_en, cur_rd_en, mask_wr_en}), 0);
                @(posedge clk); #1;
            end
            mask_full = 1'b0;
        end
        bg_empty  = 1'b1;
        cur_empty = 1'b1;
        @(negedge clk);
        check("write_timing", int'(mask_wr_en), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        bg_empty  = 1'b1;
        cur_empty = 1'b1;
        mask_full = 1'b0;
        bg_dout   = 8'd0;
        cur_dout  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({bg_rd_en, cur_rd_en, mask_wr_en, frame_done}), 0);
        check("reset_mask_din", int'(mask_din), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", int'({bg_rd_en, cur_rd_en, mask_wr_en}), 0);
            @(posedge clk); #1;
        end

        // Frame 1: pixels 0,2,4 are motion.
        send_pixel(8'd100, 8'd151, 8'hFF, 0);
        send_pixel(8'd100, 8'd150, 8'h00, 0);
        send_pixel(8'd200, 8'd10,  8'hFF, 0);

        bg_empty  = 1'b0;
        cur_empty = 1'b1;
        bg_dout   = 8'd10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("one_side_no_pop", int'({bg_rd_en, cur_rd_en}), 0);
            @(posedge clk); #1;
        end
        send_pixel(8'd10, 8'd10, 8'h00, 0);

        send_pixel(8'd0,   8'd255, 8'hFF, 5);
        send_pixel(8'd50,  8'd100, 8'h00, 0);
        send_pixel(8'd77,  8'd77,  8'h00, 0);
        send_pixel(8'd30,  8'd0,   8'h00, 0);

        // Frame 2 starts immediately, then reset hits while stalled.
        send_pixel(8'd0, 8'd200, 8'hFF, 0);
        push_exp(8'h00);
        bg_dout   = 8'd5;
        cur_dout  = 8'd6;
        bg_empty  = 1'b0;
        cur_empty = 1'b0;
        @(posedge clk); #1;
        bg_empty  = 1'b1;
        cur_empty = 1'b1;
        mask_full = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", int'({bg_rd_en, cur_rd_en, mask_wr_en, frame_done}), 0);
        check("async_reset_din", int'(mask_din), 0);
`ifdef MOTION_MASK_COUNT_EN
        check("async_reset_count", int'(motion_count), 0);
`endif
        q.delete();
        m_pix = 0;
        m_acc = 0;
        mask_full = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_quiet", int'(mask_wr_en), 0);
        @(posedge clk); #1;

        // Frame 3: full frame from pixel 0, two motion pixels.
        send_pixel(8'd0,   8'd51,  8'hFF, 0);
        send_pixel(8'd51,  8'd0,   8'hFF, 0);
        send_pixel(8'd20,  8'd70,  8'h00, 0);
        send_pixel(8'd70,  8'd20,  8'h00, 0);
        send_pixel(8'd255, 8'd255, 8'h00, 2);
        send_pixel(8'd0,   8'd0,   8'h00, 0);
        send_pixel(8'd1,   8'd50,  8'h00, 0);
        send_pixel(8'd128, 8'd130, 8'h00, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
